// File: rtl/str_pkt_pkg.sv
// Shared constants and types for the stream packetizer.
// Register offsets, counter widths and the framing FSM state.
package str_pkt_pkg;

    localparam int DN = 1;
    localparam int DW = 14;
    localparam int CW = 32;

    localparam logic [31:0] A_CTL = 32'h00;
    localparam logic [31:0] A_DEC = 32'h04;
    localparam logic [31:0] A_LEN = 32'h08;
    localparam logic [31:0] A_CNT = 32'h0C;
    localparam logic [31:0] A_STS = 32'h10;

    localparam logic [CW-1:0] DEC_RST = 32'd1;
    localparam logic [CW-1:0] LEN_RST = 32'd256;
    localparam logic [CW-1:0] CNT_RST = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_LAST
    } state_e;

    function automatic logic [CW-1:0] nz(input logic [CW-1:0] v);
        return (v == '0) ? {{(CW-1){1'b0}}, 1'b1} : v;
    endfunction

endpackage

// File: rtl/str_pkt_if.sv
// Stream and system-bus interfaces used by the packetizer.
// Stream data is DN lanes of DW bits packed into one beat.
interface axi4_stream_if #(
    parameter int DN = 1,
    parameter int DW = 14
);
    logic [DN*DW-1:0] TDATA;
    logic             TLAST;
    logic             TVALID;
    logic             TREADY;

    modport m (output TDATA, output TLAST, output TVALID, input TREADY);
    modport s (input TDATA, input TLAST, input TVALID, output TREADY);
endinterface

interface sys_bus_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        wen;
    logic        ren;
    logic        ack;
    logic        err;

    modport s (input addr, input wdata, input wen, input ren,
               output rdata, output ack, output err);
    modport m (output addr, output wdata, output wen, output ren,
               input rdata, input ack, input err);
endinterface

// File: rtl/str_pkt_regs.sv
// Register bank: bus decode, control strobes, sticky overflow
// and shadow copies of DEC/LEN/CNT latched when a run starts.
module str_pkt_regs
    import str_pkt_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    sys_bus_if.s          bus,
    input  logic          running_i,
    input  logic          ovf_set_i,
    input  logic [CW-1:0] pkt_cnt_i,
    output logic          start_o,
    output logic          stop_o,
    output logic [CW-1:0] dec_o,
    output logic [CW-1:0] len_o,
    output logic [CW-1:0] cnt_o
);

    logic          ack_q;
    logic [31:0]   rdata_q;
    logic [31:0]   rd_d;
    logic          start_q;
    logic          stop_q;
    logic          ovf_q;
    logic [CW-1:0] dec_q;
    logic [CW-1:0] len_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] dec_s_q;
    logic [CW-1:0] len_s_q;
    logic [CW-1:0] cnt_s_q;

    // Stop wins over a simultaneous start.
    assign start_o   = start_q & ~stop_q;
    assign stop_o    = stop_q;
    assign dec_o     = dec_s_q;
    assign len_o     = len_s_q;
    assign cnt_o     = cnt_s_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = 1'b0;

    always_comb begin
        rd_d = '0;
        case (bus.addr)
            A_CTL:   rd_d = {30'd0, ovf_q, running_i};
            A_DEC:   rd_d = dec_q;
            A_LEN:   rd_d = len_q;
            A_CNT:   rd_d = cnt_q;
            A_STS:   rd_d = pkt_cnt_i;
            default: rd_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dec_q   <= DEC_RST;
            len_q   <= LEN_RST;
            cnt_q   <= CNT_RST;
            dec_s_q <= DEC_RST;
            len_s_q <= LEN_RST;
            cnt_s_q <= CNT_RST;
        end else begin
            ack_q   <= bus.wen | bus.ren;
            rdata_q <= bus.ren ? rd_d : '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            if (bus.wen) begin
                case (bus.addr)
                    A_CTL: begin
                        start_q <= bus.wdata[0];
                        stop_q  <= bus.wdata[1];
                    end
                    A_DEC:   dec_q <= bus.wdata;
                    A_LEN:   len_q <= bus.wdata;
                    A_CNT:   cnt_q <= bus.wdata;
                    default: ;
                endcase
            end
            if (ovf_set_i)
                ovf_q <= 1'b1;
            else if (bus.wen && bus.addr == A_STS)
                ovf_q <= 1'b0;
            if (start_o && !running_i) begin
                dec_s_q <= nz(dec_q);
                len_s_q <= nz(len_q);
                cnt_s_q <= cnt_q;
            end
        end
    end

endmodule

// File: rtl/str_pkt.sv
// Stream packetizer: decimates the sample stream and frames it
// into TLAST-terminated packets under register control.
module str_pkt
    import str_pkt_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    axi4_stream_if.s sti,
    axi4_stream_if.m sto,
    sys_bus_if.s     bus
);

    state_e           state_q;
    logic             rdy_q;
    logic             vld_q;
    logic             last_q;
    logic [DN*DW-1:0] data_q;
    logic [CW-1:0]    dec_cnt_q;
    logic [CW-1:0]    beat_cnt_q;
    logic [CW-1:0]    pkt_cnt_q;

    logic          start;
    logic          stop;
    logic [CW-1:0] dec_s;
    logic [CW-1:0] len_s;
    logic [CW-1:0] cnt_s;
    logic          running;
    logic          accept;
    logic          dec_hit;
    logic          due;
    logic          is_last;
    logic          send;
    logic          pend;
    logic          done;
    logic          ovf_set;
    logic [CW-1:0] pkt_inc;

    str_pkt_regs u_regs (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .running_i (running),
        .ovf_set_i (ovf_set),
        .pkt_cnt_i (pkt_cnt_q),
        .start_o   (start),
        .stop_o    (stop),
        .dec_o     (dec_s),
        .len_o     (len_s),
        .cnt_o     (cnt_s)
    );

    assign sti.TREADY = rdy_q;
    assign sto.TVALID = vld_q;
    assign sto.TDATA  = data_q;
    assign sto.TLAST  = last_q;

    assign running = (state_q != ST_IDLE);
    assign accept  = sti.TVALID & rdy_q & running;
    assign dec_hit = (dec_cnt_q == dec_s - 1'b1);
    assign due     = accept & dec_hit;
    assign is_last = (beat_cnt_q == len_s - 1'b1);
    assign send    = vld_q & sto.TREADY;
    assign pend    = vld_q & ~send;
    assign pkt_inc = (pkt_cnt_q == '1) ? pkt_cnt_q : pkt_cnt_q + 1'b1;
    assign done    = (cnt_s != '0) && (pkt_inc == cnt_s);
    assign ovf_set = due & pend;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b0;
            vld_q      <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
            dec_cnt_q  <= '0;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (send)
                vld_q <= 1'b0;
            if (accept)
                dec_cnt_q <= dec_hit ? '0 : dec_cnt_q + 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_RUN;
                        dec_cnt_q  <= '0;
                        beat_cnt_q <= '0;
                        pkt_cnt_q  <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        if (pend) begin
                            last_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (due) begin
                            vld_q   <= 1'b1;
                            data_q  <= sti.TDATA;
                            last_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_LAST;
                        end
                    end else if (due) begin
                        beat_cnt_q <= is_last ? '0 : beat_cnt_q + 1'b1;
                        if (is_last)
                            pkt_cnt_q <= pkt_inc;
                        if (!pend) begin
                            vld_q  <= 1'b1;
                            data_q <= sti.TDATA;
                            last_q <= is_last;
                        end
                        // A dropped final beat still ends the run cleanly.
                        if (is_last && done) begin
                            state_q <= ST_IDLE;
                            if (pend)
                                last_q <= 1'b1;
                        end
                    end
                end
                ST_LAST: begin
                    if (due && !pend) begin
                        vld_q   <= 1'b1;
                        data_q  <= sti.TDATA;
                        last_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/str_pkt.md
# str_pkt

Stream packetizer placed directly upstream of `str2mm`. Takes the free-running ADC sample stream, decimates it by a programmable factor, and frames the result into AXI4-stream packets of programmable length, with `TLAST` on each packet's final beat. A `sys_bus` register bank provides start/stop control, packet count and a sticky overflow flag, so `str2mm` receives cleanly terminated blocks.

## Interface
- `DN`, 1: samples (lanes) per stream beat; lanes are processed together as one beat.
- `DT`, `logic signed [14-1:0]`: sample type.
- `CW`, 32: width of the decimation, length and count registers.
- `clk`  input  1  system clock, all logic on rising edge.
- `rstn`  input  1  reset, asynchronous, active-low.
- `sti`  `axi4_stream_if` slave  DN×DT  input sample stream (ACLK=`clk`, ARESETn=`rstn`).
- `sto`  `axi4_stream_if` master  DN×DT  packetized output stream toward `str2mm`.
- `bus`  `sys_bus_if` slave  32-bit  configuration/status.

## Operation
- Register map (byte offsets, 32-bit):
  - 0x00 CTL: write bit0=start, bit1=stop (strobes); read bit0=running, bit1=overflow (sticky).
  - 0x04 DEC: decimation; one output beat per DEC accepted input beats; 0 treated as 1; reset 1.
  - 0x08 LEN: beats per packet; 0 treated as 1; reset 256.
  - 0x0C CNT: packets per run; 0 = unlimited; reset 0.
  - 0x10 STS: read-only count of packets completed in current run; write 0x10 clears overflow flag.
  - Unmapped addresses: read 0, ack normally, `err`=0.
- `sti.TREADY` = 1 whenever out of reset; source is never back-pressured. In IDLE, input beats are discarded.
- FSM states IDLE, RUN, LAST.
  - IDLE → RUN on start: clears decimation counter, beat counter, packet counter.
  - RUN: every DEC-th accepted input beat is loaded into the output register (plain sample selection, no averaging). The beat that completes LEN beats carries `TLAST`. After `TLAST` is loaded and packet count reaches CNT (CNT≠0), go to IDLE.
  - RUN → LAST on stop: if output register holds an unsent beat, its `TLAST` is forced to 1 and the FSM goes to IDLE directly. Otherwise the next decimated beat is emitted with `TLAST`, then IDLE.
  - Start while RUN/LAST: ignored. Stop in IDLE: ignored. Simultaneous start+stop write: stop wins.
- Output register is one entry. If a decimated beat is due while the register is still valid and not being accepted this cycle, the new beat is dropped, overflow is set, and beat/LEN counting still advances (packet framing is preserved; `TLAST` is still issued on schedule if it lands on a sent beat).
- Register writes to DEC/LEN/CNT take effect at the next start; shadow copies are latched at start.

## Timing
- Reset: `sto.TVALID`=0, `TDATA`=0, `TLAST`=0, `sti.TREADY`=0 during reset, `bus.ack`=0, `rdata`=0, FSM=IDLE, overflow=0.
- Latency: input beat accepted at cycle k appears on `sto` at k+1.
- `sto.TVALID` is held with stable `TDATA`/`TLAST` until `TREADY`. Same-cycle accept and reload are allowed, giving full throughput at DEC=1.
- Bus: `ack` one cycle after `wen`/`ren`. A start write in cycle k means the first input beat is counted at k+2.
- Counters wrap-free: LEN/DEC comparisons use `CW`-bit equality; the packet counter saturates at 2^CW−1.
- Reset mid-packet: everything returns to reset values immediately; no `TLAST` is emitted.

## Structure
- Shared package `str_pkt_pkg`: register offset constants and the FSM state enum.
- One sub-module: `str_pkt_regs` (sys_bus decode, shadow registers, strobes). The FSM and datapath stay in `str_pkt`.

## Test plan
- DEC=1, LEN=4, CNT=2; ramp −8..7 with `sto` always ready → 8 output beats −8..−1, `TLAST` on −5 and −1, then IDLE with running=0 and STS=2.
- DEC=3, LEN=2, CNT=1; ramp 0..11 → outputs 2, 5 with `TLAST` on 5, then IDLE.
- DEC=1, LEN=8, CNT=0; `sto.TREADY` low for 3 cycles mid-stream → overflow=1, dropped beats absent, `TLAST` still on the 8th-counted beat. A write to 0x10 clears overflow.
- Unlimited run with stop written while the output register holds an unsent beat → that beat is emitted with `TLAST`=1, no further beats, running=0.
- Stop while the register is empty, DEC=4 → exactly one more beat, with `TLAST`, then IDLE.
- `rstn` asserted mid-packet → `TVALID` drops asynchronously, registers read back reset values (DEC=1, LEN=256, CNT=0).
